// File: rtl/data_mem_master.sv
// Data-port initiator for the shared memory: sequences byte/16-bit loads and stores as byte accesses.
// Optional sign extension of byte loads is enabled by defining DATA_MEM_MASTER_SIGNEXT_EN.
module data_mem_master #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_wide,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                resp_valid,
    output logic [2*DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_wen,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

`ifdef DATA_MEM_MASTER_SIGNEXT_EN
    localparam bit SignExtEn = 1'b1;
`else
    localparam bit SignExtEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StWrLo,
        StWrHi,
        StRdAddr,
        StRdLo,
        StRdHi
    } state_e;

    state_e              state;
    logic                wide_q;
    logic                signed_q;
    logic [DATA_W-1:0]   wdata_hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [2*DATA_W-1:0] byte_load;

    assign req_ready = (state == StIdle);
    assign busy      = (state != StIdle);

    always_comb begin
        byte_load = {{DATA_W{1'b0}}, mem_rdata};
        if (SignExtEn && signed_q && mem_rdata[DATA_W-1]) begin
            byte_load[2*DATA_W-1:DATA_W] = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            wide_q     <= 1'b0;
            signed_q   <= 1'b0;
            wdata_hi_q <= '0;
            lo_q       <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wen    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        wide_q     <= req_wide;
                        signed_q   <= req_signed;
                        wdata_hi_q <= req_wdata[2*DATA_W-1:DATA_W];
                        mem_addr   <= req_addr;
                        if (req_we) begin
                            mem_wdata <= req_wdata[DATA_W-1:0];
                            mem_wen   <= 1'b1;
                            state     <= StWrLo;
                        end else begin
                            state     <= StRdAddr;
                        end
                    end
                end
                StWrLo: begin
                    if (wide_q) begin
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= wdata_hi_q;
                        state     <= StWrHi;
                    end else begin
                        mem_wen    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        state      <= StIdle;
                    end
                end
                StWrHi: begin
                    mem_wen    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    state      <= StIdle;
                end
                StRdAddr: begin
                    // Issue the high-byte address while the low byte is being read.
                    if (wide_q) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                    state <= StRdLo;
                end
                StRdLo: begin
                    if (wide_q) begin
                        lo_q  <= mem_rdata;
                        state <= StRdHi;
                    end else begin
                        resp_rdata <= byte_load;
                        resp_valid <= 1'b1;
                        state      <= StIdle;
                    end
                end
                StRdHi: begin
                    resp_rdata <= {mem_rdata, lo_q};
                    resp_valid <= 1'b1;
                    state      <= StIdle;
                end
                default: begin
                    mem_wen <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_master.sv
// Directed bench for data_mem_master with a synchronous-read byte memory model.
module tb_data_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_we, req_wide, req_signed;
    logic        req_ready, resp_valid, mem_wen, busy;
    logic [7:0]  req_addr, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] req_wdata, resp_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] mem [0:255];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;
    wr_t wlog[$];

    typedef struct packed {
        logic        we;
        logic        wide;
        logic        sgn;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [3:0]  exp_lat;
    } vec_t;

`ifdef DATA_MEM_MASTER_SIGNEXT_EN
    localparam logic [15:0] Sx80 = 16'hFF80;
`else
    localparam logic [15:0] Sx80 = 16'h0080;
`endif

    data_mem_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wide  (req_wide),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back('{mem_addr, mem_wdata, cyc});
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge with the master idle; returns accept-to-response latency.
    task automatic do_req(input vec_t v, output int lat, output logic [15:0] rdata,
                          output logic ready_at_resp);
        req_we     = v.we;
        req_wide   = v.wide;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = 8'hEE;
        req_wdata  = 16'hDEAD;
        check("busy_after_accept", {31'd0, req_ready}, 32'd0);
        lat = -1;
        rdata = '0;
        ready_at_resp = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = n;
                rdata = resp_rdata;
                ready_at_resp = req_ready;
                break;
            end
        end
    endtask

    vec_t vecs [14];

    initial begin
        int          lat;
        int          t1, t2, npulse;
        logic [15:0] rd, d1, d2;
        logic        rdy;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h40, 16'h0080, 16'h0000, 4'd1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h51, 16'hC35A, 16'h0000, 4'd1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h10, 16'h00A5, 16'h0000, 4'd1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h20, 16'hBEEF, 16'h0000, 4'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 16'hBEEF, 4'd3};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, 16'h0000, 4'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 16'h0000, 16'h1234, 4'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0012, 4'd2};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h40, 16'h0000, Sx80,     4'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h40, 16'h0000, 16'h0080, 4'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h21, 16'h0000, 16'h00BE, 4'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h51, 16'h0000, 16'h005A, 4'd2};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h30, 16'h0077, 16'h0000, 4'd1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h31, 16'hFF88, 16'h0000, 4'd1};

        req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
        check("rst_mem_addr",   {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata",  {24'd0, mem_wdata}, 32'd0);
        check("rst_mem_wen",    {31'd0, mem_wen}, 32'd0);
        check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i], lat, rd, rdy);
            check($sformatf("vec%0d_latency", i), lat, {28'd0, vecs[i].exp_lat});
            check($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
            check($sformatf("vec%0d_ready_at_resp", i), {31'd0, rdy}, 32'd1);
        end

        // Write trace: byte store single write, wide stores on consecutive cycles, wrap to 0x00.
        check("wlog_count_after_vecs", wlog.size(), 9);
        if (wlog.size() >= 9) begin
            check("wr_byte_addr",  {24'd0, wlog[2].addr}, 32'h10);
            check("wr_byte_data",  {24'd0, wlog[2].data}, 32'hA5);
            check("wr_wide_lo",    {wlog[3].addr, wlog[3].data}, 32'h20EF);
            check("wr_wide_hi",    {wlog[4].addr, wlog[4].data}, 32'h21BE);
            check("wr_wide_consec", wlog[4].cyc - wlog[3].cyc, 1);
            check("wr_wrap_lo",    {wlog[5].addr, wlog[5].data}, 32'hFF34);
            check("wr_wrap_hi",    {wlog[6].addr, wlog[6].data}, 32'h0012);
            check("wr_wrap_consec", wlog[6].cyc - wlog[5].cyc, 1);
            check("wr_b2b_hi_byte_only", {wlog[8].addr, wlog[8].data}, 32'h3188);
        end

        // Back-to-back byte loads with req_valid held high.
        req_we = 1'b0; req_wide = 1'b0; req_signed = 1'b0;
        req_addr = 8'h30; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 8'h31;
        t1 = -1; t2 = -1; npulse = 0; d1 = '0; d2 = '0; rdy = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                npulse++;
                if (t1 < 0) begin
                    t1 = n; d1 = resp_rdata; rdy = req_ready;
                end else if (t2 < 0) begin
                    t2 = n; d2 = resp_rdata;
                end
            end
            // Second request is taken at the edge closing the first response cycle.
            if (t1 > 0 && n == t1 + 1) req_valid = 1'b0;
        end
        check("b2b_first_latency", t1, 2);
        check("b2b_first_rdata", {16'd0, d1}, 32'h0077);
        check("b2b_ready_in_resp_cycle", {31'd0, rdy}, 32'd1);
        // Accept one edge after the first pulse, plus the 2-cycle byte-load latency.
        check("b2b_pulse_spacing", t2 - t1, 3);
        check("b2b_second_rdata", {16'd0, d2}, 32'h0088);
        check("b2b_pulse_count", npulse, 2);
        check("b2b_rdata_held", {16'd0, resp_rdata}, 32'h0088);

        // Reset during the high-byte write of a wide store.
        req_we = 1'b1; req_wide = 1'b1; req_addr = 8'h50; req_wdata = 16'h3311;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_wen_in_wr_hi", {31'd0, mem_wen}, 32'd1);
        check("abort_addr_in_wr_hi", {24'd0, mem_addr}, 32'h51);
        rst_n = 1'b0;
        #1;
        check("abort_wen_async_drop", {31'd0, mem_wen}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        npulse = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (resp_valid) npulse++;
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        if (resp_valid) npulse++;
        check("abort_no_resp", npulse, 0);
        check("abort_ready_after", {31'd0, req_ready}, 32'd1);
        check("abort_wlog_count", wlog.size(), 10);

        do_req('{1'b0, 1'b0, 1'b0, 8'h51, 16'h0, 16'h0, 4'd2}, lat, rd, rdy);
        check("abort_hi_unchanged", {16'd0, rd}, 32'h005A);
        do_req('{1'b0, 1'b0, 1'b0, 8'h50, 16'h0, 16'h0, 4'd2}, lat, rd, rdy);
        check("abort_lo_written", {16'd0, rd}, 32'h0011);
        check("abort_lo_latency", lat, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
